// File: rtl/spi_reg_controller_pkg.sv
// Shared types and constants for the SPI register-file transaction controller.
package spi_reg_controller_pkg;
  localparam int CMD_READ_BIT = 7;
  localparam int ADDR_W       = 7;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    RD_FETCH,
    RD_LOAD,
    RD_WAIT
  } state_t;
endpackage

// File: rtl/spi_reg_controller_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
  // Pulses flag the value o_sync is about to take, so a registered consumer
  // changes state in the same cycle that o_sync changes.
  assign o_rise = r_meta & ~r_sync;
  assign o_fall = ~r_meta & r_sync;
endmodule

// File: rtl/spi_reg_controller.sv
// Frames SPI transfers by slave select, decodes the command byte and runs
// auto-incrementing register writes/reads, feeding read bytes to the SPI transmit path.
module spi_reg_controller
  import spi_reg_controller_pkg::*;
#(
  parameter int         REG_COUNT = 64,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic              clk_system,
  input  logic              reset,
  input  logic              spi_select_n,
  input  logic              spi_new_data,
  input  logic [7:0]        spi_rd_data,
  output logic              spi_latch,
  output logic [7:0]        spi_wr_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wr_data,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rd_data,
  output logic              frame_active,
  output logic              frame_done,
  output logic              addr_error
);
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_reg_addr, w_acc_addr;
  logic [7:0]        r_reg_wr_data, r_spi_wr_data, w_load_byte;
  logic              r_reg_wr_en, r_reg_rd_en, r_rd_valid, r_latch_start;
  logic              r_frame_done, r_addr_error;
  logic              w_sel, w_rise, w_fall, w_in_range;
  logic              w_start, w_end, w_cmd_wr, w_write, w_fetch, w_load;

  sync_edge_detect #(.RESET_VAL(1'b1)) u_sel_sync (
    .i_clk   (clk_system),
    .i_reset (reset),
    .i_async (spi_select_n),
    .o_sync  (w_sel),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clk_system) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Frame end overrides everything, so a byte arriving with it is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_cmd_wr    = 1'b0;
    w_write     = 1'b0;
    w_fetch     = 1'b0;
    w_load      = 1'b0;
    w_acc_addr  = r_addr;
    if (r_state != IDLE && w_rise) begin
      w_state_nxt = IDLE;
      w_end       = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_fall) begin
          w_state_nxt = CMD;
          w_start     = 1'b1;
        end
        CMD: if (spi_new_data) begin
          w_acc_addr = spi_rd_data[ADDR_W-1:0];
          if (spi_rd_data[CMD_READ_BIT]) begin
            w_state_nxt = RD_FETCH;
            w_fetch     = 1'b1;
          end else begin
            w_state_nxt = WRITE;
            w_cmd_wr    = 1'b1;
          end
        end
        WRITE:    w_write = spi_new_data;
        RD_FETCH: w_state_nxt = RD_LOAD;
        RD_LOAD: begin
          w_load      = 1'b1;
          w_state_nxt = RD_WAIT;
        end
        RD_WAIT: if (spi_new_data) begin
          w_fetch     = 1'b1;
          w_state_nxt = RD_FETCH;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_in_range  = ({25'd0, w_acc_addr} < REG_COUNT);
  assign w_load_byte = r_rd_valid ? reg_rd_data : FILL_BYTE;

  always_ff @(posedge clk_system) begin
    if (reset) begin
      r_addr        <= '0;
      r_reg_addr    <= '0;
      r_reg_wr_data <= '0;
      r_reg_wr_en   <= 1'b0;
      r_reg_rd_en   <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_latch_start <= 1'b0;
      r_spi_wr_data <= '0;
      r_frame_done  <= 1'b0;
      r_addr_error  <= 1'b0;
    end else begin
      r_reg_wr_en   <= 1'b0;
      r_reg_rd_en   <= 1'b0;
      r_latch_start <= 1'b0;
      r_frame_done  <= w_end;
      if (w_start) begin
        r_latch_start <= 1'b1;
        r_spi_wr_data <= FILL_BYTE;
        r_addr_error  <= 1'b0;
      end
      if (w_cmd_wr) r_addr <= w_acc_addr;
      if (w_write) begin
        r_reg_addr    <= w_acc_addr;
        r_reg_wr_data <= spi_rd_data;
        r_reg_wr_en   <= w_in_range;
        r_addr        <= w_acc_addr + 7'd1;
        if (!w_in_range) r_addr_error <= 1'b1;
      end
      if (w_fetch) begin
        r_reg_addr  <= w_acc_addr;
        r_reg_rd_en <= w_in_range;
        r_rd_valid  <= w_in_range;
        r_addr      <= w_acc_addr + 7'd1;
        if (!w_in_range) r_addr_error <= 1'b1;
      end
      if (w_load) r_spi_wr_data <= w_load_byte;
    end
  end

  // Read data arrives in the RD_LOAD cycle itself, so that latch is combinational.
  assign spi_latch    = r_latch_start | (w_load & ~reset);
  assign spi_wr_data  = w_load ? w_load_byte : r_spi_wr_data;
  assign reg_addr     = r_reg_addr;
  assign reg_wr_en    = r_reg_wr_en;
  assign reg_wr_data  = r_reg_wr_data;
  assign reg_rd_en    = r_reg_rd_en;
  assign frame_active = ~w_sel;
  assign frame_done   = r_frame_done;
  assign addr_error   = r_addr_error;
endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench: table of whole frames plus hand-timed sequences for latency, abort and reset.
module tb_spi_reg_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_n = 1'b1;
  logic       new_data = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  logic       latch, wr_en, rd_en, active, done, err;
  logic [7:0] tx_byte, wr_data;
  logic [6:0] addr;
  logic [7:0] rd_data = 8'h00;

  logic       latch_b, wr_en_b, rd_en_b, active_b, done_b, err_b;
  logic [7:0] tx_byte_b, wr_data_b;
  logic [6:0] addr_b;
  logic [7:0] rd_data_b = 8'h00;

  logic [7:0] mem [128];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_controller #(.REG_COUNT(64), .FILL_BYTE(8'h00)) dut (
    .clk_system(clk), .reset(rst), .spi_select_n(sel_n), .spi_new_data(new_data),
    .spi_rd_data(rx_byte), .spi_latch(latch), .spi_wr_data(tx_byte), .reg_addr(addr),
    .reg_wr_en(wr_en), .reg_wr_data(wr_data), .reg_rd_en(rd_en), .reg_rd_data(rd_data),
    .frame_active(active), .frame_done(done), .addr_error(err)
  );

  spi_reg_controller #(.REG_COUNT(128), .FILL_BYTE(8'h00)) dut128 (
    .clk_system(clk), .reset(rst), .spi_select_n(sel_n), .spi_new_data(new_data),
    .spi_rd_data(rx_byte), .spi_latch(latch_b), .spi_wr_data(tx_byte_b), .reg_addr(addr_b),
    .reg_wr_en(wr_en_b), .reg_wr_data(wr_data_b), .reg_rd_en(rd_en_b), .reg_rd_data(rd_data_b),
    .frame_active(active_b), .frame_done(done_b), .addr_error(err_b)
  );

  // Register file model: data valid the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (rd_en)   rd_data   <= mem[addr];
    if (rd_en_b) rd_data_b <= mem[addr_b];
  end

  logic [6:0] q_wa[$];
  logic [7:0] q_wd[$];
  logic [6:0] q_ra[$];
  logic [7:0] q_lat[$];
  logic [6:0] q_ra128[$];
  int         n_done = 0;

  always @(negedge clk) begin
    if (wr_en) begin q_wa.push_back(addr); q_wd.push_back(wr_data); end
    if (rd_en) q_ra.push_back(addr);
    if (latch) q_lat.push_back(tx_byte);
    if (rd_en_b) q_ra128.push_back(addr_b);
    if (done) n_done++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    new_data = 1'b1; rx_byte = b;
    cyc(1);
    new_data = 1'b0;
    cyc(7);
  endtask

  task automatic run_frame(input logic [3:0][7:0] b, input int nb);
    sel_n = 1'b0;
    cyc(4);
    for (int i = 0; i < nb; i++) send_byte(b[i]);
    sel_n = 1'b1;
    cyc(6);
  endtask

  typedef struct {
    logic [3:0][7:0] b;
    int              nb;
    int              nwr;
    logic [2:0][6:0] wa;
    logic [2:0][7:0] wd;
    int              nrd;
    logic [2:0][6:0] ra;
    int              nlat;
    logic [3:0][7:0] lat;
    logic            err;
  } vec_t;

  vec_t vt[5];

  initial begin
    int bw, bd, br, bl, bn;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[10] = 8'h12; mem[11] = 8'h34; mem[12] = 8'h77;
    mem[62] = 8'h5A; mem[63] = 8'hA5; mem[64] = 8'hEE;
    mem[3]  = 8'h3C; mem[127] = 8'h9F; mem[0] = 8'h01;

    // write 05,AA,55 -> (5,AA),(6,55)
    vt[0] = '{b: {8'h00, 8'h55, 8'hAA, 8'h05}, nb: 3, nwr: 2, wa: {7'd0, 7'd6, 7'd5},
              wd: {8'h00, 8'h55, 8'hAA}, nrd: 0, ra: '0, nlat: 1, lat: '0, err: 1'b0};
    // read 8A,00,00 -> fetch 10,11,12; latches 00,12,34,77
    vt[1] = '{b: {8'h00, 8'h00, 8'h00, 8'h8A}, nb: 3, nwr: 0, wa: '0, wd: '0, nrd: 3,
              ra: {7'd12, 7'd11, 7'd10}, nlat: 4, lat: {8'h77, 8'h34, 8'h12, 8'h00}, err: 1'b0};
    // write from 63: only 63 strobes, 64/65 flag error
    vt[2] = '{b: {8'h03, 8'h02, 8'h01, 8'h3F}, nb: 4, nwr: 1, wa: {7'd0, 7'd0, 7'd63},
              wd: {8'h00, 8'h00, 8'h01}, nrd: 0, ra: '0, nlat: 1, lat: '0, err: 1'b1};
    // read from 62: 62,63 fetched, 64 loads fill byte with no strobe
    vt[3] = '{b: {8'h00, 8'h00, 8'h00, 8'hBE}, nb: 3, nwr: 0, wa: '0, wd: '0, nrd: 2,
              ra: {7'd0, 7'd63, 7'd62}, nlat: 4, lat: {8'h00, 8'hA5, 8'h5A, 8'h00}, err: 1'b1};
    // command-only frame: error from previous frame must be cleared
    vt[4] = '{b: {8'h00, 8'h00, 8'h00, 8'h10}, nb: 1, nwr: 0, wa: '0, wd: '0, nrd: 0,
              ra: '0, nlat: 1, lat: '0, err: 1'b0};

    cyc(3);
    chk("rst_latch",   32'(latch), 32'd0);
    chk("rst_txdata",  32'(tx_byte), 32'd0);
    chk("rst_addr",    32'(addr), 32'd0);
    chk("rst_wr_en",   32'(wr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_en",   32'(rd_en), 32'd0);
    chk("rst_active",  32'(active), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_err",     32'(err), 32'd0);
    rst = 1'b0;
    cyc(3);

    for (int v = 0; v < 5; v++) begin
      bw = q_wa.size(); br = q_ra.size(); bl = q_lat.size(); bn = n_done; bd = bw;
      run_frame(vt[v].b, vt[v].nb);
      chk($sformatf("v%0d_nwr", v), 32'(q_wa.size() - bw), 32'(vt[v].nwr));
      for (int i = 0; i < vt[v].nwr && bw + i < q_wa.size(); i++) begin
        chk($sformatf("v%0d_wa%0d", v, i), 32'(q_wa[bw + i]), 32'(vt[v].wa[i]));
        chk($sformatf("v%0d_wd%0d", v, i), 32'(q_wd[bd + i]), 32'(vt[v].wd[i]));
      end
      chk($sformatf("v%0d_nrd", v), 32'(q_ra.size() - br), 32'(vt[v].nrd));
      for (int i = 0; i < vt[v].nrd && br + i < q_ra.size(); i++)
        chk($sformatf("v%0d_ra%0d", v, i), 32'(q_ra[br + i]), 32'(vt[v].ra[i]));
      chk($sformatf("v%0d_nlat", v), 32'(q_lat.size() - bl), 32'(vt[v].nlat));
      for (int i = 0; i < vt[v].nlat && bl + i < q_lat.size(); i++)
        chk($sformatf("v%0d_lat%0d", v, i), 32'(q_lat[bl + i]), 32'(vt[v].lat[i]));
      chk($sformatf("v%0d_done", v), 32'(n_done - bn), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(err), 32'(vt[v].err));
    end

    // Cycle-exact frame start, write and frame end
    sel_n = 1'b0;
    cyc(1);
    chk("t_active_c1", 32'(active), 32'd0);
    cyc(1);
    chk("t_active_c2", 32'(active), 32'd1);
    chk("t_latch_c2",  32'(latch), 32'd1);
    chk("t_fill_c2",   32'(tx_byte), 32'h00);
    cyc(1);
    chk("t_latch_c3",  32'(latch), 32'd0);
    new_data = 1'b1; rx_byte = 8'h20;
    cyc(1);
    new_data = 1'b0;
    chk("t_cmd_no_wr", 32'(wr_en), 32'd0);
    cyc(2);
    new_data = 1'b1; rx_byte = 8'hC3;
    cyc(1);
    new_data = 1'b0;
    chk("t_wr_en",   32'(wr_en), 32'd1);
    chk("t_wr_addr", 32'(addr), 32'h20);
    chk("t_wr_data", 32'(wr_data), 32'hC3);
    cyc(1);
    chk("t_wr_en_off", 32'(wr_en), 32'd0);
    sel_n = 1'b1;
    cyc(1);
    chk("t_done_c1", 32'(done), 32'd0);
    cyc(1);
    chk("t_done_c2",   32'(done), 32'd1);
    chk("t_active_off", 32'(active), 32'd0);
    cyc(1);
    chk("t_done_c3", 32'(done), 32'd0);
    cyc(3);

    // Cycle-exact read latency
    sel_n = 1'b0;
    cyc(4);
    new_data = 1'b1; rx_byte = 8'h8B;
    cyc(1);
    new_data = 1'b0;
    chk("r_rd_en_t1", 32'(rd_en), 32'd1);
    chk("r_addr_t1",  32'(addr), 32'd11);
    chk("r_latch_t1", 32'(latch), 32'd0);
    cyc(1);
    chk("r_latch_t2", 32'(latch), 32'd1);
    chk("r_data_t2",  32'(tx_byte), 32'h34);
    cyc(1);
    chk("r_latch_t3", 32'(latch), 32'd0);
    sel_n = 1'b1;
    cyc(6);

    // Wrap at 127 on the 128-register instance
    br = q_ra128.size();
    run_frame({8'h00, 8'h00, 8'h00, 8'hFF}, 2);
    chk("w_nrd", 32'(q_ra128.size() - br), 32'd2);
    if (q_ra128.size() >= br + 2) begin
      chk("w_ra0", 32'(q_ra128[br]), 32'd127);
      chk("w_ra1", 32'(q_ra128[br + 1]), 32'd0);
    end
    chk("w_err", 32'(err_b), 32'd0);

    // Abort: byte coincides with frame end in WRITE
    sel_n = 1'b0;
    cyc(4);
    send_byte(8'h20);
    bw = q_wa.size(); bn = n_done;
    sel_n = 1'b1;
    cyc(1);
    new_data = 1'b1; rx_byte = 8'h99;
    cyc(1);
    new_data = 1'b0;
    cyc(5);
    chk("a_no_wr", 32'(q_wa.size() - bw), 32'd0);
    chk("a_done",  32'(n_done - bn), 32'd1);
    br = q_ra.size();
    run_frame({8'h00, 8'h00, 8'h00, 8'h83}, 1);
    chk("a_new_cmd_nrd", 32'(q_ra.size() - br), 32'd1);
    if (q_ra.size() > br) chk("a_new_cmd_ra", 32'(q_ra[br]), 32'd3);

    // Reset during RD_LOAD
    sel_n = 1'b0;
    cyc(4);
    new_data = 1'b1; rx_byte = 8'h8A;
    cyc(1);
    new_data = 1'b0;
    cyc(1);
    bn = n_done;
    rst = 1'b1;
    #1;
    chk("x_latch_in_load", 32'(latch), 32'd0);
    cyc(1);
    chk("x_latch",  32'(latch), 32'd0);
    chk("x_rd_en",  32'(rd_en), 32'd0);
    chk("x_wr_en",  32'(wr_en), 32'd0);
    chk("x_active", 32'(active), 32'd0);
    chk("x_done",   32'(done), 32'd0);
    chk("x_err",    32'(err), 32'd0);
    chk("x_tx",     32'(tx_byte), 32'd0);
    chk("x_addr",   32'(addr), 32'd0);
    sel_n = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    chk("x_no_done", 32'(n_done - bn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
